// File: rtl/dot_pkg.sv
// Shared sizing helpers and types for the dot-product result collector.
//   out_size(in0,in1)       : partial-sum width produced by the dot unit
//   res_size(out,max_tiles) : accumulated result width with tile headroom
//   dl_entry_t              : one delay-line stage {vld, last}
//   part_pair_t             : partial-sum pair at the default operand sizes
package dot_pkg;

  function automatic int out_size(input int in0, input int in1);
    return in0 + in1 + 8;
  endfunction

  function automatic int res_size(input int osz, input int max_tiles);
    return osz + $clog2(max_tiles);
  endfunction

  localparam int OUT_SIZE_DEF = out_size(4, 8);
  localparam int RES_SIZE_DEF = res_size(OUT_SIZE_DEF, 16);

  typedef struct packed {
    logic vld;
    logic last;
  } dl_entry_t;

  typedef logic [1:0][OUT_SIZE_DEF-1:0] part_pair_t;

endpackage

// File: rtl/dot_result_collector_if.sv
// Issue/result bundle between the dot-unit producer, the collector and the
// result consumer.
//   issue_valid/issue_last/issue_ready : operand tile issue handshake
//   part                               : partial-sum pair from the dot unit
//   res_valid/res_ready/res_data       : finished-result stream
//   err                                : sticky overflow debug flag
// slave = collector side, master = environment side.
interface dot_result_collector_if #(
  parameter int OUT_SIZE = 20,
  parameter int RES_SIZE = 24
);
  logic                     issue_valid;
  logic                     issue_last;
  logic                     issue_ready;
  logic [1:0][OUT_SIZE-1:0] part;
  logic                     res_valid;
  logic                     res_ready;
  logic [RES_SIZE-1:0]      res_data;
  logic                     err;

  modport slave (
    input  issue_valid, issue_last, part, res_ready,
    output issue_ready, res_valid, res_data, err
  );

  modport master (
    output issue_valid, issue_last, part, res_ready,
    input  issue_ready, res_valid, res_data, err
  );
endinterface

// File: rtl/result_fifo.sv
// Show-ahead result FIFO. DEPTH must be a power of two so the pointers wrap
// by plain overflow.
//   clk_i, rst_ni   : clock, async active-low reset
//   push_i, data_i  : write request and data
//   pop_i           : read request (ignored when empty)
//   data_o          : head entry (valid whenever !empty_o)
//   count_o         : occupancy
//   full_o, empty_o : status
// A push while full is dropped unless a pop happens on the same edge.
module result_fifo #(
  parameter  int WIDTH = 24,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [AW:0]                 count_q;
  logic                        do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // When full, the pop frees the head slot, which is exactly where wr_ptr
  // points, so the write lands safely behind the departing entry.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push & ~do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop & ~do_push) count_q <= count_q - 1'b1;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/dot_result_collector.sv
// Consumer side of the fixed-latency dot-product unit. Tracks accepted
// operand tiles through a LATENCY-deep {vld,last} delay line, sums the two
// partial sums on arrival, accumulates across tiles of one product and
// queues finished products in a show-ahead FIFO.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : issue handshake, partial sums, result stream, err
// issue_ready is a credit check: FIFO entries plus lasts still in flight
// must stay below FIFO_DEPTH, so the FIFO can never overflow.
// MAX_TILES must be >= 2; the interface must be sized with the same
// OUT_SIZE/RES_SIZE as derived here.
module dot_result_collector
  import dot_pkg::*;
#(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_TILES  = 16
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  dot_result_collector_if.slave bus
);
  localparam int OUT_SIZE = out_size(IN_SIZE_0, IN_SIZE_1);
  localparam int RES_SIZE = res_size(OUT_SIZE, MAX_TILES);
  localparam int EXT      = RES_SIZE - OUT_SIZE;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(FIFO_DEPTH + LATENCY + 1);

  dl_entry_t [LATENCY-1:0] dl_q, dl_d;
  logic [RES_SIZE-1:0]     acc_q;
  logic                    first_q;
  logic                    err_q;

  logic                    accept, arrive, arrive_last, pop;
  logic [CW-1:0]           inflight, used;
  logic [RES_SIZE-1:0]     p0_ext, p1_ext, tile_sum, acc_sum;
  logic [AW:0]             fifo_count;
  logic                    fifo_full, fifo_empty;

  assign accept = bus.issue_valid & bus.issue_ready;

  always_comb begin
    dl_d        = dl_q;
    dl_d[0].vld  = accept;
    dl_d[0].last = accept & bus.issue_last;
    for (int i = 1; i < LATENCY; i++) dl_d[i] = dl_q[i-1];
  end

  // Lasts still travelling the delay line have a FIFO slot reserved.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(dl_q[i].last);
  end

  assign used            = CW'(fifo_count) + inflight;
  assign bus.issue_ready = (used < CW'(FIFO_DEPTH));

  assign arrive      = dl_q[LATENCY-1].vld;
  assign arrive_last = arrive & dl_q[LATENCY-1].last;

  assign p0_ext   = {{EXT{bus.part[0][OUT_SIZE-1]}}, bus.part[0]};
  assign p1_ext   = {{EXT{bus.part[1][OUT_SIZE-1]}}, bus.part[1]};
  assign tile_sum = p0_ext + p1_ext;
  // first_q restarts the product without a separate clear cycle.
  assign acc_sum  = (first_q ? '0 : acc_q) + tile_sum;

  assign pop = bus.res_valid & bus.res_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dl_q    <= '0;
      acc_q   <= '0;
      first_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      dl_q <= dl_d;
      if (arrive) begin
        acc_q   <= acc_sum;
        first_q <= dl_q[LATENCY-1].last;
      end
      if (arrive_last & fifo_full & ~pop) err_q <= 1'b1;
    end
  end

  result_fifo #(
    .WIDTH (RES_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (arrive_last),
    .data_i  (acc_sum),
    .pop_i   (pop),
    .data_o  (bus.res_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.res_valid = ~fifo_empty;
  assign bus.err       = err_q;
endmodule
